// File: rtl/vc_mem_pkg.sv
// rtl/vc_mem_pkg.sv - shared types and defaults for the victim cache memory responder
package vc_mem_pkg;

    localparam int DEF_TAG_WIDTH  = 20;
    localparam int DEF_LINE_BYTES = 16;

    typedef logic [DEF_LINE_BYTES*8-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/vc_mem_store.sv
// rtl/vc_mem_store.sv - tag-indexed backing store with synchronous write and combinational read
module vc_mem_store #(
    parameter int TAG_WIDTH  = 20,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [TAG_WIDTH-1:0]  wtag,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rvalid,
    output logic [TAG_WIDTH-1:0]  rtag,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DEPTH-1:0]      valid;
    logic [TAG_WIDTH-1:0]  tags [DEPTH];
    logic [DATA_WIDTH-1:0] data [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            tags[idx] <= wtag;
            data[idx] <= wdata;
        end
    end

    assign rvalid = valid[idx];
    assign rtag   = tags[idx];
    assign rdata  = data[idx];

endmodule

// File: rtl/vc_mem_responder.sv
// rtl/vc_mem_responder.sv - single-outstanding memory responder with programmable latency
module vc_mem_responder
    import vc_mem_pkg::*;
#(
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req,
    input  logic                    mem_req_write,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic [LINE_BYTES*8-1:0] mem_req_wdata,
    output logic                    mem_resp_valid,
    output logic [LINE_BYTES*8-1:0] mem_resp_rdata,
    output logic                    mem_resp_hit,
    output logic                    busy,
    output logic                    proto_err,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count
);

    localparam int DW    = LINE_BYTES * 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_t               state;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 req_write;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [DW-1:0]        req_wdata;

    logic                 st_valid;
    logic [TAG_WIDTH-1:0] st_tag;
    logic [DW-1:0]        st_data;
    logic                 st_we;
    logic                 lookup_hit;
    logic                 req_changed;

    assign st_we       = (state == RESP) && req_write;
    assign lookup_hit  = st_valid && (st_tag == req_tag);
    assign req_changed = (mem_req_write != req_write) || (mem_req_tag != req_tag) ||
                         (mem_req_wdata != req_wdata);

    vc_mem_store #(
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (st_we),
        .idx    (req_tag[IDX_W-1:0]),
        .wtag   (req_tag),
        .wdata  (req_wdata),
        .rvalid (st_valid),
        .rtag   (st_tag),
        .rdata  (st_data)
    );

    // The store is touched on the edge leaving RESP, so the response registers
    // and the pulse appear together in the cycle after edge accept+LATENCY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            req_write      <= 1'b0;
            req_tag        <= '0;
            req_wdata      <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_rdata <= '0;
            mem_resp_hit   <= 1'b0;
            busy           <= 1'b0;
            proto_err      <= 1'b0;
            wr_count       <= '0;
            rd_count       <= '0;
        end else begin
            mem_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        req_write <= mem_req_write;
                        req_tag   <= mem_req_tag;
                        req_wdata <= mem_req_wdata;
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            lat_cnt <= LAT_W'(LATENCY - 2);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_req || req_changed) begin
                        proto_err <= 1'b1;
                    end
                    if (lat_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    mem_resp_valid <= 1'b1;
                    if (req_write) begin
                        mem_resp_hit <= 1'b1;
                        if (wr_count != '1) begin
                            wr_count <= wr_count + 1'b1;
                        end
                    end else begin
                        mem_resp_hit   <= lookup_hit;
                        mem_resp_rdata <= lookup_hit ? st_data : '0;
                        if (rd_count != '1) begin
                            rd_count <= rd_count + 1'b1;
                        end
                    end
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!mem_req) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_mem_responder.sv
// tb/tb_vc_mem_responder.sv - directed self-checking bench for vc_mem_responder
module tb_vc_mem_responder;

    logic         clk;
    logic         rst_n;
    logic         mem_req;
    logic         mem_req_write;
    logic [19:0]  mem_req_tag;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
    logic         mem_resp_hit;
    logic         busy;
    logic         proto_err;
    logic [15:0]  wr_count;
    logic [15:0]  rd_count;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    vc_mem_responder #(
        .TAG_WIDTH  (20),
        .LINE_BYTES (16),
        .DEPTH      (16),
        .LATENCY    (2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_req_write  (mem_req_write),
        .mem_req_tag    (mem_req_tag),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_hit   (mem_resp_hit),
        .busy           (busy),
        .proto_err      (proto_err),
        .wr_count       (wr_count),
        .rd_count       (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_req(input logic w, input logic [19:0] tag, input logic [127:0] wd);
        @(posedge clk); #1;
        mem_req       = 1'b1;
        mem_req_write = w;
        mem_req_tag   = tag;
        mem_req_wdata = wd;
    endtask

    task automatic wait_resp(output int lat, output logic hit, output logic [127:0] rd);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_resp_valid) begin
                lat = i;
                break;
            end
        end
        hit = mem_resp_hit;
        rd  = mem_resp_rdata;
    endtask

    task automatic do_txn(input logic w, input logic [19:0] tag, input logic [127:0] wd,
                          output int lat, output logic hit, output logic [127:0] rd);
        start_req(w, tag, wd);
        wait_resp(lat, hit, rd);
        mem_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_req = 1'b0; mem_req_write = 1'b0; mem_req_tag = '0; mem_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_resp_valid, mem_resp_hit, busy, proto_err} !== 4'b0 ||
            mem_resp_rdata !== 128'h0 || wr_count !== 16'h0 || rd_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b hit=%b busy=%b perr=%b rdata=%h wr=%0d rd=%0d, want all 0",
                     mem_resp_valid, mem_resp_hit, busy, proto_err, mem_resp_rdata, wr_count, rd_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss;
        int lat; logic hit; logic [127:0] rd;
        start_req(1'b0, 20'h5, '0);
        wait_resp(lat, hit, rd);
        exp_rd++;
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL miss_latency: got %0d edges, want 3", lat); end
        checks++;
        if (hit !== 1'b0 || rd !== 128'h0) begin
            errors++; $display("FAIL miss_data: hit=%b rdata=%h, want hit=0 rdata=0", hit, rd);
        end
        checks++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            errors++; $display("FAIL miss_counts: rd=%0d wr=%0d, want rd=%0d wr=%0d", rd_count, wr_count, exp_rd, exp_wr);
        end
        mem_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_resp_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: valid=%b, want 0", mem_resp_valid); end
    endtask

    task automatic test_write_read;
        int lat; logic hit; logic [127:0] rd;
        do_txn(1'b1, 20'hA, 128'hA, lat, hit, rd);
        exp_wr++;
        checks++;
        if (lat !== 3 || hit !== 1'b1 || wr_count !== 16'(exp_wr)) begin
            errors++; $display("FAIL write_resp: lat=%0d hit=%b wr=%0d, want lat=3 hit=1 wr=%0d", lat, hit, wr_count, exp_wr);
        end
        do_txn(1'b0, 20'hA, '0, lat, hit, rd);
        exp_rd++;
        checks++;
        if (hit !== 1'b1 || rd !== 128'hA || rd_count !== 16'(exp_rd)) begin
            errors++; $display("FAIL read_after_write: hit=%b rdata=%h rd=%0d, want hit=1 rdata=a rd=%0d", hit, rd, rd_count, exp_rd);
        end
    endtask

    task automatic test_overwrite;
        int lat; logic hit; logic [127:0] rd;
        do_txn(1'b1, 20'h1A, 128'h1A1A_0000_0000_0000_0000_0000_0000_1A1A, lat, hit, rd);
        exp_wr++;
        do_txn(1'b0, 20'hA, '0, lat, hit, rd);
        exp_rd++;
        checks++;
        if (hit !== 1'b0 || rd !== 128'h0) begin
            errors++; $display("FAIL evicted_tag: hit=%b rdata=%h, want hit=0 rdata=0", hit, rd);
        end
        do_txn(1'b0, 20'h1A, '0, lat, hit, rd);
        exp_rd++;
        checks++;
        if (hit !== 1'b1 || rd !== 128'h1A1A_0000_0000_0000_0000_0000_0000_1A1A) begin
            errors++; $display("FAIL new_tag: hit=%b rdata=%h, want hit=1 rdata=1a1a...1a1a", hit, rd);
        end
        checks++;
        if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
            errors++; $display("FAIL overwrite_counts: wr=%0d rd=%0d, want wr=%0d rd=%0d", wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    task automatic test_hold;
        int lat; logic hit; logic [127:0] rd;
        int pulses;
        int busy_low;
        start_req(1'b1, 20'h7, 128'h77);
        wait_resp(lat, hit, rd);
        exp_wr++;
        pulses = (lat > 0) ? 1 : 0;
        busy_low = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_resp_valid) pulses++;
            if (!busy) busy_low++;
        end
        mem_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_low !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_busy: low_while_held=%0d busy_after_drop=%b, want 0 and 0", busy_low, busy);
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_resp_valid) pulses++;
        end
        checks++;
        if (pulses !== 1 || wr_count !== 16'(exp_wr)) begin
            errors++; $display("FAIL hold_single: pulses=%0d wr=%0d, want 1 and %0d", pulses, wr_count, exp_wr);
        end
    endtask

    task automatic test_proto;
        int lat; logic hit; logic [127:0] rd;
        do_txn(1'b1, 20'h2, 128'h2222, lat, hit, rd);
        exp_wr++;
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: perr=%b, want 0", proto_err); end
        start_req(1'b0, 20'h2, '0);
        @(posedge clk); #1;
        mem_req_tag = 20'h5;
        wait_resp(lat, hit, rd);
        exp_rd++;
        mem_req = 1'b0;
        checks++;
        if (lat !== 2 || hit !== 1'b1 || rd !== 128'h2222) begin
            errors++; $display("FAIL proto_uses_captured: lat=%0d hit=%b rdata=%h, want lat=2 hit=1 rdata=2222", lat, hit, rd);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: perr=%b, want 1", proto_err); end
    endtask

    task automatic test_reset_mid;
        int lat; logic hit; logic [127:0] rd;
        int pulses;
        start_req(1'b1, 20'h3, 128'h3333);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_req = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_resp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0 || wr_count !== 16'h0 || rd_count !== 16'h0 || proto_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: pulses=%0d wr=%0d rd=%0d perr=%b busy=%b, want all 0",
                               pulses, wr_count, rd_count, proto_err, busy);
        end
        do_txn(1'b0, 20'h3, '0, lat, hit, rd);
        exp_rd++;
        checks++;
        if (lat !== 3 || hit !== 1'b0 || rd !== 128'h0 || rd_count !== 16'(exp_rd)) begin
            errors++; $display("FAIL reset_no_store: lat=%0d hit=%b rdata=%h rd=%0d, want lat=3 hit=0 rdata=0 rd=%0d",
                               lat, hit, rd, rd_count, exp_rd);
        end
    endtask

    initial begin
        test_reset;
        test_read_miss;
        test_write_read;
        test_overwrite;
        test_hold;
        test_proto;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
